// File: rtl/volume_level_gen.sv
// volume_level_gen: turns a stream of unsigned microphone samples into a
// 0..15 volume bar level, refreshed once per WINDOW samples.
//
// Each sample becomes an amplitude above the silence midpoint. The largest
// amplitude in a window sets the target level (128 amplitude codes per
// step). A louder window raises the bar at once. A quieter window lowers it
// one step per window, or drops it straight to the target when DECAY_EN=0.
// While hold is high the bar stays frozen, but the window timing keeps running.
//
// State table:
//   state  | meaning
//   ACCUM  | collecting samples for the current window
//   UPDATE | one cycle after a window closes; outputs refresh at its end
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   sample_valid  one-cycle strobe qualifying mic_in
//   mic_in        12-bit unsigned microphone sample
//   hold          freezes volume_level (level_valid/peak_amp still update)
//   volume_level  registered bar level 0..15
//   level_valid   one-cycle pulse per completed window
//   peak_amp      peak amplitude of the last completed window
module volume_level_gen #(
  parameter int WINDOW   = 4000,
  parameter int MIDPOINT = 2048,
  parameter bit DECAY_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [11:0] mic_in,
  input  logic        hold,
  output logic [3:0]  volume_level,
  output logic        level_valid,
  output logic [10:0] peak_amp
);

  localparam int             CW       = $clog2(WINDOW);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WINDOW - 1);

  typedef enum logic {ACCUM, UPDATE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt;
  logic [10:0]   peak;
  logic [10:0]   win_peak;
  logic [10:0]   amp;
  logic [10:0]   peak_max;
  logic          window_end;
  logic [3:0]    target;
  logic [3:0]    level_d;
  int            diff;

  // Amplitude above midpoint; values below silence clamp to 0. A very small
  // MIDPOINT could push the difference past 11 bits, so saturate instead of wrap.
  always_comb begin
    diff = int'(mic_in) - MIDPOINT;
    amp  = '0;
    if (diff > 2047)
      amp = 11'h7FF;
    else if (diff > 0)
      amp = diff[10:0];
  end

  assign peak_max   = (amp > peak) ? amp : peak;
  assign window_end = sample_valid && (cnt == CNT_LAST);
  assign target     = win_peak[10:7];

  always_comb begin
    state_d = state_q;
    level_d = volume_level;
    case (state_q)
      ACCUM: begin
        if (window_end)
          state_d = UPDATE;
      end
      UPDATE: begin
        state_d = ACCUM;
        if (!hold) begin
          if (target >= volume_level)
            level_d = target;
          else if (DECAY_EN)
            level_d = volume_level - 4'd1;  // target < level, so never wraps
          else
            level_d = target;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      cnt          <= '0;
      peak         <= '0;
      win_peak     <= '0;
      volume_level <= '0;
      level_valid  <= 1'b0;
      peak_amp     <= '0;
    end else begin
      state_q     <= state_d;
      level_valid <= (state_q == UPDATE);
      // Accumulation runs regardless of state: a sample in the UPDATE cycle
      // is sample 0 of the following window.
      if (sample_valid) begin
        if (window_end) begin
          win_peak <= peak_max;
          peak     <= '0;
          cnt      <= '0;
        end else begin
          peak <= peak_max;
          cnt  <= cnt + CW'(1);
        end
      end
      if (state_q == UPDATE) begin
        peak_amp     <= win_peak;
        volume_level <= level_d;
      end
    end
  end

endmodule

// File: doc/volume_level_gen.md
VOLUME_LEVEL_GEN -- requirements
Module: volume_level_gen

Interface
REQ-001 SHALL have parameter WINDOW, default 4000, meaning samples per measurement window (legal range WINDOW >= 2; 4000 = 200 ms at 20 kHz).
REQ-002 SHALL have parameter MIDPOINT, default 2048, meaning the unsigned microphone code for silence.
REQ-003 SHALL have parameter DECAY_EN, default 1, meaning 1 = falling level drops one step per window, 0 = level jumps straight down.
REQ-004 SHALL have port clk  input  1  system clock; the block uses one clock only.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port sample_valid  input  1  one-cycle strobe qualifying mic_in.
REQ-007 SHALL have port mic_in  input  12  unsigned microphone sample.
REQ-008 SHALL have port hold  input  1  freeze request for volume_level.
REQ-009 SHALL have port volume_level  output  4  registered level 0..15, feeds the volume bar display.
REQ-010 SHALL have port level_valid  output  1  one-cycle pulse marking each window update.
REQ-011 SHALL have port peak_amp  output  11  registered peak amplitude of the last completed window.

Function
REQ-012 SHALL compute amp = mic_in - MIDPOINT when mic_in >= MIDPOINT, else 0, as an 11-bit value (range 0..2047, no wrap).
REQ-013 SHALL keep a sample counter cnt (width clog2(WINDOW)) and a running peak register; both change only on sample_valid cycles.
REQ-014 On sample_valid with cnt < WINDOW-1: peak <= max(peak, amp), cnt <= cnt+1.
REQ-015 On sample_valid with cnt == WINDOW-1 (edge E):
- win_peak <= max(peak, amp)
- peak <= 0
- cnt <= 0
- state ACCUM -> UPDATE
REQ-016 State machine SHALL have two states: ACCUM, which is the default, and UPDATE, which lasts exactly one cycle and always returns to ACCUM.
REQ-017 Accumulation SHALL continue unaffected during UPDATE; a sample_valid in the UPDATE cycle counts as sample 0 of the next window.
REQ-018 In UPDATE, SHALL form target = win_peak[10:7] (128 amplitude codes per level).
REQ-019 At edge E+1, unless hold:
- target >= volume_level: volume_level <= target
- target < volume_level and DECAY_EN=1: volume_level <= volume_level-1
- target < volume_level and DECAY_EN=0: volume_level <= target
REQ-020 When hold=1 in the UPDATE cycle, volume_level SHALL keep its value; level_valid and peak_amp SHALL still update.
REQ-021 At edge E+1 SHALL set peak_amp <= win_peak and level_valid <= 1; level_valid SHALL be high for exactly one cycle per window.
REQ-022 Latency SHALL be: final sample accepted at edge E, outputs visible after edge E+1.
REQ-023 volume_level SHALL saturate within 0..15 and SHALL never wrap (decay stops at the target).
REQ-024 hold SHALL NOT affect cnt, peak or window timing.

Reset
REQ-025 When rst=1 at a clock edge, SHALL set:
- volume_level = 0, level_valid = 0, peak_amp = 0
- cnt = 0, peak = 0, win_peak = 0
- state = ACCUM
REQ-026 rst SHALL take priority over sample_valid in the same cycle; that sample SHALL be discarded.
REQ-027 Reset mid-window or during UPDATE SHALL abandon the partial window with no level_valid pulse; the next window SHALL need WINDOW fresh samples.

Verification (WINDOW=4, MIDPOINT=2048, DECAY_EN=1 unless noted)
REQ-028 Reset: assert rst 2 cycles with sample_valid toggling -> volume_level=0, level_valid=0, peak_amp=0.
REQ-029 Basic window:
- stimulus: samples 2048, 2500, 3000, 2100
- response 1 cycle after last sample: peak_amp=952, volume_level=7, level_valid high exactly 1 cycle
REQ-030 Decay:
- stimulus: after REQ-029, three windows of all-2048 samples
- response: volume_level 6, 5, 4
- with DECAY_EN=0, first such window -> 0
REQ-031 Boundaries: a window containing 4095 -> level 15, peak_amp=2047; a window of all-1000 samples -> amp 0, peak_amp=0.
REQ-032 Hold and back-to-back:
- stimulus: hold=1 over a 4095 window while level=4; sample_valid every cycle
- response: level stays 4, level_valid still pulses; the UPDATE-cycle sample is counted in the next window
REQ-033 Reset mid-window:
- stimulus: rst after 2 samples, then 3 samples
- response: no level_valid until the 4th post-reset sample
